// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-back, write-allocate data cache that
// serves 16-bit CPU words and moves 64-bit lines to and from memory.
// Optional feature macro: DATA_CACHE_STATS_EN adds access_count / miss_count.
module data_cache_ctrl #(
  parameter int unsigned NUM_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_write_data,
  output logic [15:0] cpu_read_data,
  output logic        cpu_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data,
  input  logic        mem_ack
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] access_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS   = 16 - 2 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } state_t;

  state_t state_q;
  state_t state_d;

  // Per-line storage
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [63:0]          data_q [NUM_LINES];

  // Request captured at miss time so the miss finishes even if the CPU lets go
  logic [INDEX_BITS-1:0] miss_index_q;
  logic [TAG_BITS-1:0]   miss_tag_q;

  logic [1:0]            req_offset;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  req_valid;
  logic [63:0]           req_line;
  logic [15:0]           req_word;
  logic                  hit;
  logic                  victim_dirty;
  logic                  write_hit;
  logic                  miss_start;
  logic                  wb_done;
  logic                  fill_done;

  // Address split and combinational lookup
  assign req_offset   = cpu_address[1:0];
  assign req_index    = cpu_address[2 +: INDEX_BITS];
  assign req_tag      = cpu_address[15 -: TAG_BITS];
  assign req_valid    = cpu_read | cpu_write;
  assign req_line     = data_q[req_index];
  assign req_word     = req_line[{req_offset, 4'b0000} +: 16];
  assign hit          = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign victim_dirty = valid_q[req_index] & dirty_q[req_index];
  assign wb_done      = (state_q == ST_WRITEBACK) & mem_ack;
  assign fill_done    = (state_q == ST_FILL) & mem_ack;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; a write wins when read and write are both high
  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_read_data  = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    write_hit      = 1'b0;
    miss_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (hit) begin
            cpu_ready = 1'b1;
            if (cpu_write) begin
              write_hit = 1'b1;
            end else begin
              cpu_read_data = req_word;
            end
          end else begin
            miss_start = 1'b1;
            state_d    = victim_dirty ? ST_WRITEBACK : ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_write      = 1'b1;
        mem_address    = {tag_q[miss_index_q], miss_index_q, 2'b00};
        mem_write_data = data_q[miss_index_q];
        if (mem_ack) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, miss_index_q, 2'b00};
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the missing request's index and tag
  always_ff @(posedge clk) begin
    if (miss_start) begin
      miss_index_q <= req_index;
      miss_tag_q   <= req_tag;
    end
  end

  // Valid and dirty bits; reset drops every line, dirty data included
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (write_hit) begin
        dirty_q[req_index] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_index_q] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: word update on write hit, whole line on fill
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_q[req_index][{req_offset, 4'b0000} +: 16] <= cpu_write_data;
    end
    if (fill_done) begin
      tag_q[miss_index_q]  <= miss_tag_q;
      data_q[miss_index_q] <= mem_read_data;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  // Access and miss counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (cpu_ready) begin
        access_count <= access_count + 16'd1;
      end
      if (miss_start) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: a 4-cycle memory model, a
// line-level cache model plus a flat word view of memory as the reference.
module tb_data_cache_ctrl;

  localparam int unsigned NUM_LINES = 4;
  localparam int MEM_LAT  = 4;
  localparam int MAX_WAIT = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [15:0] cpu_write_data;
  logic [15:0] cpu_read_data;
  logic        cpu_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        mem_ack;
  logic        model_ack;
  logic        stray_ack;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] access_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int fails  = 0;

  // Backing memory and the CPU-visible word values
  logic [15:0] backing [65536];
  logic [15:0] golden  [65536];

  // Reference cache contents: which line base address each slot holds
  logic        ref_valid [NUM_LINES];
  logic        ref_dirty [NUM_LINES];
  logic [15:0] ref_base  [NUM_LINES];

  // Completed memory transactions: {is_write, line address}
  logic [16:0] txn_q [$];
  logic [63:0] last_wb;

  data_cache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .cpu_ready(cpu_ready),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_ack(mem_ack)
`ifdef DATA_CACHE_STATS_EN
    ,
    .access_count(access_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  assign mem_ack = model_ack | stray_ack;

  function automatic logic [63:0] golden_line(input logic [15:0] base);
    return {golden[int'(base) + 3], golden[int'(base) + 2], golden[int'(base) + 1], golden[int'(base)]};
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if (ref_valid[i] && ref_dirty[i]) begin
        for (int k = 0; k < 4; k++) golden[int'(ref_base[i]) + k] = backing[int'(ref_base[i]) + k];
      end
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_base[i]  = '0;
    end
  endfunction

  // Predict latency, memory traffic and read data for one access, then update the model
  function automatic void ref_access(input logic is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                                     output int exp_lat, output logic [15:0] exp_rdata, output int exp_ntx,
                                     output logic [16:0] exp_tx0, output logic [16:0] exp_tx1);
    int idx;
    logic [15:0] base;
    base    = addr & 16'hFFFC;
    idx     = int'(addr >> 2) % int'(NUM_LINES);
    exp_ntx = 0;
    exp_tx0 = '0;
    exp_tx1 = '0;
    if (ref_valid[idx] && ref_base[idx] == base) begin
      exp_lat = 0;
    end else begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_tx0 = {1'b1, ref_base[idx]};
        exp_tx1 = {1'b0, base};
        exp_ntx = 2;
        exp_lat = 2 * MEM_LAT + 1;
      end else begin
        exp_tx0 = {1'b0, base};
        exp_ntx = 1;
        exp_lat = MEM_LAT + 1;
      end
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_base[idx]  = base;
    end
    exp_rdata = golden[addr];
    if (is_wr) begin
      golden[addr]   = wdata;
      ref_dirty[idx] = 1'b1;
    end
  endfunction

  // Memory model: acks in the 4th cycle a request is held, checks exclusivity and holding
  initial begin : mem_model
    int mcnt;
    logic [15:0] mhold;
    model_ack     = 1'b0;
    mem_read_data = '0;
    mcnt          = 0;
    mhold         = '0;
    forever begin
      @(posedge clk);
      #1;
      model_ack = 1'b0;
      if (reset !== 1'b0 || !(mem_read === 1'b1 || mem_write === 1'b1)) begin
        mcnt = 0;
      end else begin
        checks++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
          fails++;
          $display("FAIL mem_exclusive: mem_read=%b mem_write=%b, required not both high", mem_read, mem_write);
        end
        mcnt++;
        checks++;
        if (mcnt == 1) begin
          mhold = mem_address;
          if (mem_address[1:0] !== 2'b00) begin
            fails++;
            $display("FAIL mem_align: address %h, required line aligned", mem_address);
          end
        end else if (mem_address !== mhold) begin
          fails++;
          $display("FAIL mem_hold: address %h, required held at %h", mem_address, mhold);
        end
        if (mcnt == MEM_LAT) begin
          model_ack = 1'b1;
          mcnt      = 0;
          if (mem_write === 1'b1) begin
            last_wb = mem_write_data;
            checks++;
            if (mem_write_data !== golden_line(mem_address)) begin
              fails++;
              $display("FAIL wb_data: got %h, required %h", mem_write_data, golden_line(mem_address));
            end
            for (int k = 0; k < 4; k++) backing[int'(mem_address) + k] = mem_write_data[16*k +: 16];
            txn_q.push_back({1'b1, mem_address});
          end else begin
            mem_read_data = {backing[int'(mem_address) + 3], backing[int'(mem_address) + 2],
                             backing[int'(mem_address) + 1], backing[int'(mem_address)]};
            txn_q.push_back({1'b0, mem_address});
          end
        end
      end
    end
  end

  // Present one request at posedge+2, count cycles until cpu_ready, then release it
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int lat);
    txn_q.delete();
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_address    = addr;
    cpu_write_data = wdata;
    lat            = 0;
    #1;
    while (cpu_ready !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #3;
      lat++;
    end
    rdata = cpu_read_data;
    @(posedge clk);
    #2;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    ref_reset();
    @(posedge clk);
    #2;
    checks++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, required 0", cpu_ready); end
    checks++;
    if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b, required 0", mem_read); end
    checks++;
    if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b, required 0", mem_write); end
    checks++;
    if (cpu_read_data !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h, required 0000", cpu_read_data); end
  endtask

  task automatic test_cold_miss();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    ref_access(1'b0, 16'h0012, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0012, 16'h0, rdata, lat);
    checks++;
    if (lat != MEM_LAT + 1) begin fails++; $display("FAIL cold_latency: got %0d, required %0d", lat, MEM_LAT + 1); end
    checks++;
    if (rdata !== 16'h3333) begin fails++; $display("FAIL cold_rdata: got %h, required 3333", rdata); end
    checks++;
    if (txn_q.size() != 1 || txn_q[0] !== {1'b0, 16'h0010}) begin
      fails++;
      $display("FAIL cold_traffic: %0d transactions, required one fill of 0010", txn_q.size());
    end
  endtask

  task automatic test_read_hit();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    ref_access(1'b0, 16'h0013, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0013, 16'h0, rdata, lat);
    checks++;
    if (lat != 0) begin fails++; $display("FAIL hit_latency: got %0d, required 0", lat); end
    checks++;
    if (rdata !== 16'h4444) begin fails++; $display("FAIL hit_rdata: got %h, required 4444", rdata); end
    checks++;
    if (txn_q.size() != 0) begin fails++; $display("FAIL hit_traffic: got %0d transactions, required 0", txn_q.size()); end
  endtask

  task automatic test_dirty_evict();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    ref_access(1'b1, 16'h0012, 16'hBEEF, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b0, 1'b1, 16'h0012, 16'hBEEF, rdata, lat);
    checks++;
    if (lat != 0) begin fails++; $display("FAIL wr_hit_latency: got %0d, required 0", lat); end
    ref_access(1'b0, 16'h0022, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0022, 16'h0, rdata, lat);
    checks++;
    if (lat != 2 * MEM_LAT + 1) begin fails++; $display("FAIL evict_latency: got %0d, required %0d", lat, 2 * MEM_LAT + 1); end
    checks++;
    if (txn_q.size() != 2 || txn_q[0] !== {1'b1, 16'h0010} || txn_q[1] !== {1'b0, 16'h0020}) begin
      fails++;
      $display("FAIL evict_traffic: %0d transactions, required writeback 0010 then fill 0020", txn_q.size());
    end
    checks++;
    if (last_wb !== 64'h4444_BEEF_2222_1111) begin fails++; $display("FAIL evict_wb_line: got %h, required 4444beef22221111", last_wb); end
    checks++;
    if (rdata !== exp_rdata) begin fails++; $display("FAIL evict_rdata: got %h, required %h", rdata, exp_rdata); end
  endtask

  task automatic test_write_allocate();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    ref_access(1'b1, 16'h0105, 16'h1234, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b0, 1'b1, 16'h0105, 16'h1234, rdata, lat);
    checks++;
    if (lat != MEM_LAT + 1) begin fails++; $display("FAIL wmiss_latency: got %0d, required %0d", lat, MEM_LAT + 1); end
    checks++;
    if (txn_q.size() != 1 || txn_q[0] !== {1'b0, 16'h0104}) begin
      fails++;
      $display("FAIL wmiss_traffic: %0d transactions, required one fill of 0104", txn_q.size());
    end
    ref_access(1'b0, 16'h0105, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0105, 16'h0, rdata, lat);
    checks++;
    if (lat != 0 || txn_q.size() != 0) begin fails++; $display("FAIL wmiss_readback_hit: latency %0d traffic %0d, required 0 and 0", lat, txn_q.size()); end
    checks++;
    if (rdata !== 16'h1234) begin fails++; $display("FAIL wmiss_readback: got %h, required 1234", rdata); end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    txn_q.delete();
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = 16'h0039;
    repeat (2) begin @(posedge clk); #2; end
    checks++;
    if (mem_read !== 1'b1) begin fails++; $display("FAIL midfill_active: mem_read=%b, required 1", mem_read); end
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset    = 1'b0;
    cpu_read = 1'b0;
    ref_reset();
    checks++;
    if (mem_read !== 1'b0) begin fails++; $display("FAIL midfill_mem_read: got %b, required 0", mem_read); end
    checks++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL midfill_ready: got %b, required 0", cpu_ready); end
    stray_ack = 1'b1;
    @(posedge clk);
    #2;
    stray_ack = 1'b0;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL stray_ack: mem_read=%b mem_write=%b, required 0 0", mem_read, mem_write); end
    checks++;
    if (txn_q.size() != 0) begin fails++; $display("FAIL midfill_abandon: got %0d completions, required 0", txn_q.size()); end
    @(posedge clk);
    #2;
    ref_access(1'b0, 16'h0039, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0039, 16'h0, rdata, lat);
    checks++;
    if (lat != MEM_LAT + 1) begin fails++; $display("FAIL refetch_latency: got %0d, required %0d", lat, MEM_LAT + 1); end
    checks++;
    if (rdata !== exp_rdata) begin fails++; $display("FAIL refetch_rdata: got %h, required %h", rdata, exp_rdata); end
  endtask

  task automatic test_drop_request();
    logic [15:0] rdata, exp_rdata, exp2;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    ref_access(1'b0, 16'h0049, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    txn_q.delete();
    cpu_read    = 1'b1;
    cpu_address = 16'h0049;
    @(posedge clk);
    #2;
    cpu_read = 1'b0;
    repeat (2 * MEM_LAT + 4) begin @(posedge clk); #2; end
    checks++;
    if (txn_q.size() != ntx || txn_q[0] !== tx0) begin fails++; $display("FAIL drop_fill: %0d transactions, required %0d", txn_q.size(), ntx); end
    ref_access(1'b0, 16'h0049, 16'h0, exp_lat, exp2, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0049, 16'h0, rdata, lat);
    checks++;
    if (lat != exp_lat || rdata !== exp2) begin fails++; $display("FAIL drop_installed: latency %0d data %h, required %0d %h", lat, rdata, exp_lat, exp2); end
  endtask

  task automatic test_random();
    logic [15:0] rdata, exp_rdata, addr, wdata;
    logic [16:0] tx0, tx1;
    logic rd, wr, ok;
    int lat, exp_lat, ntx, kind;
    for (int n = 0; n < 200; n++) begin
      addr  = 16'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
      kind  = int'($urandom_range(0, 3));
      rd    = (kind != 2);
      wr    = (kind >= 2);
      wdata = 16'($urandom);
      ref_access(wr, addr, wdata, exp_lat, exp_rdata, ntx, tx0, tx1);
      do_access(rd, wr, addr, wdata, rdata, lat);
      checks++;
      if (lat != exp_lat) begin fails++; $display("FAIL rand_latency[%0d] addr %h: got %0d, required %0d", n, addr, lat, exp_lat); end
      ok = (txn_q.size() == ntx);
      if (ok && ntx > 0) ok = (txn_q[0] === tx0);
      if (ok && ntx > 1) ok = (txn_q[1] === tx1);
      checks++;
      if (!ok) begin fails++; $display("FAIL rand_traffic[%0d] addr %h: got %0d transactions, required %0d", n, addr, txn_q.size(), ntx); end
      if (!wr) begin
        checks++;
        if (rdata !== exp_rdata) begin fails++; $display("FAIL rand_rdata[%0d] addr %h: got %h, required %h", n, addr, rdata, exp_rdata); end
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #2; end
    end
  endtask

`ifdef DATA_CACHE_STATS_EN
  task automatic test_stats();
    logic [15:0] rdata, exp_rdata;
    logic [16:0] tx0, tx1;
    int lat, exp_lat, ntx;
    test_reset();
    ref_access(1'b0, 16'h0012, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0012, 16'h0, rdata, lat);
    ref_access(1'b0, 16'h0013, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0013, 16'h0, rdata, lat);
    ref_access(1'b0, 16'h0010, 16'h0, exp_lat, exp_rdata, ntx, tx0, tx1);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0, rdata, lat);
    checks++;
    if (access_count !== 16'd3) begin fails++; $display("FAIL stats_access: got %0d, required 3", access_count); end
    checks++;
    if (miss_count !== 16'd1) begin fails++; $display("FAIL stats_miss: got %0d, required 1", miss_count); end
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset          = 1'b1;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_address    = '0;
    cpu_write_data = '0;
    stray_ack      = 1'b0;
    last_wb        = '0;
    for (int a = 0; a < 65536; a++) begin
      backing[a] = 16'(a * 40503 + 7);
      golden[a]  = backing[a];
    end
    backing[16'h0010] = 16'h1111;
    backing[16'h0011] = 16'h2222;
    backing[16'h0012] = 16'h3333;
    backing[16'h0013] = 16'h4444;
    for (int a = 16'h0010; a < 16'h0014; a++) golden[a] = backing[a];
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_base[i]  = '0;
    end
    @(posedge clk);
    #2;
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_dirty_evict();
    test_write_allocate();
    test_reset_mid_fill();
    test_drop_request();
    test_random();
`ifdef DATA_CACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and the 64-bit line-wide memory.
- Serves 16-bit word reads and writes from the CPU.
- Fetches and evicts 4-word (64-bit) lines to and from memory with a request/ack handshake.
- The CPU stalls its MEM stage while cpu_ready is low.

Parameters:
- NUM_LINES, 4: number of cache lines. Power of two, ≥2. INDEX_BITS = log2(NUM_LINES); tag = 16 − 2 − INDEX_BITS bits.

Ports:
- clk  in  1  system clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- cpu_read  in  1  CPU load request
- cpu_write  in  1  CPU store request
- cpu_address  in  16  word address
- cpu_write_data  in  16  store data
- cpu_read_data  out  16  load data, valid when cpu_ready=1
- cpu_ready  out  1  access completes this cycle
- mem_read  out  1  line fill request
- mem_write  out  1  line writeback request
- mem_address  out  16  line-aligned address (bits [1:0]=0)
- mem_write_data  out  64  victim line
- mem_read_data  in  64  fill line, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Address split: offset = addr[1:0], index = addr[2+INDEX_BITS-1:2], tag = remaining upper bits.
- Line word i occupies bits [16i+15:16i] on both memory buses.
- Per line storage: valid, dirty, tag, and 64-bit data.
- Reset (any cycle, including mid-miss):
  - All valid and dirty bits clear; FSM goes to IDLE.
  - mem_read=0, mem_write=0, cpu_ready=0, cpu_read_data=0 from the next cycle.
  - Any in-flight memory transaction is abandoned; dirty data is lost.
- Request rules:
  - The CPU holds cpu_read/cpu_write, address and data stable until the cycle cpu_ready=1.
  - If cpu_read and cpu_write are both high, the access is a write.
  - cpu_ready is 0 when no request is present.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - Lookup is combinational. Hit = valid & tag match.
  - Read hit: cpu_ready=1 and cpu_read_data=word in the same cycle (0-cycle latency).
  - Write hit: cpu_ready=1 the same cycle; the word is updated and dirty set at the clock edge.
  - Miss with a clean or invalid victim: go to FILL.
  - Miss with a dirty valid victim: go to WRITEBACK.
  - mem_ack is ignored while in IDLE.
- WRITEBACK:
  - mem_write=1, mem_address={victim tag, index, 2'b00}, mem_write_data=victim line.
  - These outputs are held until mem_ack. On mem_ack: clear dirty, go to FILL.
- FILL:
  - mem_read=1, mem_address={req tag, index, 2'b00}, held until mem_ack.
  - On mem_ack: install mem_read_data, set valid=1, dirty=0, tag=request tag, go to IDLE.
  - The held request then hits in IDLE on the next cycle.
- cpu_ready=0 in WRITEBACK and FILL.
- Miss latency: clean miss = memory latency + 1 cycle; dirty miss = two memory latencies + 1 cycle.
- If the CPU drops its request mid-miss, the fill still completes and the line is installed; no cpu_ready is issued.
- mem_read and mem_write are never high together.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN
- Defined: adds outputs access_count (16, out) and miss_count (16, out). Both reset to 0 and wrap at 16 bits.
  - access_count increments on every cycle with cpu_ready=1.
  - miss_count increments on each IDLE→WRITEBACK or IDLE→FILL transition.
  - Hits = access_count − miss_count.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Memory model with a 4-cycle ack is used in every scenario.
- Cold read miss: after reset, read 0x0012 with memory line 0x0010 = {0x4444,0x3333,0x2222,0x1111} → mem_read with mem_address=0x0010 held 4 cycles; cpu_ready arrives 1 cycle after mem_ack with data 0x3333.
- Read hit: read 0x0013 immediately after the fill → cpu_ready=1 in the same cycle with data 0x4444; mem_read stays 0.
- Dirty eviction (NUM_LINES=4): write 0xBEEF to 0x0012 (hit), then read 0x0022 (same index, different tag) → mem_write with address 0x0010 and data {0x4444,0xBEEF,0x2222,0x1111}; then mem_read with address 0x0020; cpu_ready returns the word at 0x0022.
- Write miss allocate: write 0x1234 to 0x0105 (clean miss) → fill of line 0x0104, then write hit on the next cycle; a later read of 0x0105 returns 0x1234 with no memory traffic.
- Reset mid-FILL: assert reset 2 cycles into a fill → mem_read=0 on the next cycle; a later read of the same address misses again; a stray mem_ack arriving in IDLE is ignored.
- Stats (DATA_CACHE_STATS_EN): run the sequence cold miss, hit, hit → access_count=3, miss_count=1.
